// File: rtl/divider_pkg.sv
// Shared ALU constants for the divider: operand width, status nibble bit
// positions, FSM state encodings and a status-nibble packing helper.
package divider_pkg;

    localparam int ALU_WIDTH = 16;

    localparam int ST_CARRY    = 0;
    localparam int ST_NEG      = 1;
    localparam int ST_ZERO     = 2;
    localparam int ST_OVERFLOW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // Carry is never produced by a division, so it is always packed as 0.
    function automatic logic [3:0] pack_status(input logic neg,
                                               input logic zero,
                                               input logic ovf);
        logic [3:0] s;
        s              = 4'b0000;
        s[ST_CARRY]    = 1'b0;
        s[ST_NEG]      = neg;
        s[ST_ZERO]     = zero;
        s[ST_OVERFLOW] = ovf;
        return s;
    endfunction

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore, and shift
// the resulting quotient bit into the low end of the quotient register.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;
    logic           q_bit;

    // The partial remainder is always below the divisor, so one extra bit is
    // enough to hold the shifted value and detect a borrow.
    assign partial = {rem_in, quo_in[WIDTH-1]};
    assign diff    = partial - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], q_bit};

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, MSB first.
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands
// (magnitudes are divided, signs fixed up on the final iteration).
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; operands latched on the accepting edge
// S_CALC | WIDTH iterations of div_step, counted down by count
// S_DONE | results valid, done pulses for this single cycle
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [3:0]       statusOut
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             ovf_r;

    logic             accept;
    logic             div_zero;
    logic             last_iter;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             ovf_in;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic [3:0]       status_final;

    assign div_zero  = (operand2 == '0);
    assign last_iter = (count == CW'(1));

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic neg1;
    logic neg2;
    logic neg_q_r;
    logic neg_r_r;

    assign neg1    = operand1[WIDTH-1];
    assign neg2    = operand2[WIDTH-1];
    assign mag1    = neg1 ? (~operand1 + WIDTH'(1)) : operand1;
    assign mag2    = neg2 ? (~operand2 + WIDTH'(1)) : operand2;
    // MOST_NEG / -1 divides cleanly as magnitudes and wraps back to MOST_NEG
    // after negation; only the flag needs to be raised.
    assign ovf_in  = (operand1 == MOST_NEG) && (operand2 == '1);
    assign q_final = neg_q_r ? (~step_quo + WIDTH'(1)) : step_quo;
    assign r_final = neg_r_r ? (~step_rem + WIDTH'(1)) : step_rem;
`else
    assign mag1    = operand1;
    assign mag2    = operand2;
    assign ovf_in  = 1'b0;
    assign q_final = step_quo;
    assign r_final = step_rem;
`endif

    assign status_final = pack_status(q_final[WIDTH-1], (q_final == '0), ovf_r);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_w),
        .quo_in  (quo_w),
        .divisor (divisor_r),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; start is only looked at in S_IDLE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate in S_CALC, and publish the
    // results on the last iteration so they are valid for the whole S_DONE
    // cycle and held until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            divisor_r <= '0;
            rem_w     <= '0;
            quo_w     <= '0;
            ovf_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            statusOut <= '0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
`endif
        end else if (accept) begin
            if (div_zero) begin
                quotient  <= '1;
                remainder <= operand1;
                statusOut <= pack_status(1'b1, 1'b0, 1'b1);
            end else begin
                rem_w     <= '0;
                quo_w     <= mag1;
                divisor_r <= mag2;
                count     <= CW'(WIDTH);
                ovf_r     <= ovf_in;
`ifdef DIVIDER_SIGNED_EN
                neg_q_r   <= neg1 ^ neg2;
                neg_r_r   <= neg1;
`endif
            end
        end else if (state == S_CALC) begin
            rem_w <= step_rem;
            quo_w <= step_quo;
            count <= count - CW'(1);
            if (last_iter) begin
                quotient  <= q_final;
                remainder <= r_final;
                statusOut <= status_final;
            end
        end
    end

endmodule
